imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-002 SHALL have parameter DEPTH, default 64, word count (power of two, >= 2); CNT_W = clog2(DEPTH)+1.
REQ-003 SHALL have parameter HALT_WORD, default 32'h0000007F, word returned on any faulted fetch.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, reset is asynchronous and active-low.
REQ-005 SHALL have ports: ld_start in 1, begin/restart load; ld_valid in 1; ld_data in DATA_W; ld_last in 1, marks final load word; ld_ready out 1.
REQ-006 SHALL have ports: req in 1, fetch request; pc in 32, byte address.
REQ-007 SHALL have ports: rsp_valid out 1; inst out DATA_W; fault out 1; fault_cause out 2 (01 misaligned, 10 out of range, 11 not loaded).
REQ-008 SHALL have ports: mem_ready out 1, memory loaded; loaded_cnt out CNT_W, words loaded; ovf out 1, sticky load overflow.

Function
REQ-009 SHALL implement FSM states EMPTY, LOAD, READY; reset state EMPTY.
REQ-010 EMPTY: ld_start -> LOAD, write pointer and loaded_cnt cleared, ovf cleared.
REQ-011 LOAD: ld_ready = 1 while pointer < DEPTH; word accepted when ld_valid & ld_ready, written to mem[pointer], pointer and loaded_cnt increment by 1.
REQ-012 LOAD: accepted word with ld_last -> READY next cycle; mem_ready = 1 from that cycle.
REQ-013 LOAD full (pointer == DEPTH): ld_ready = 0; ld_valid while full sets ovf and is dropped; ld_last with ld_valid while full still -> READY.
REQ-014 READY: ld_start -> LOAD, clearing pointer, loaded_cnt, ovf, mem_ready; memory contents beyond new loaded_cnt are treated as not loaded.
REQ-015 ld_start in LOAD SHALL restart the load (pointer and loaded_cnt to 0) and drop any same-cycle ld_valid word.
REQ-016 Fetch SHALL have fixed latency 1: req at cycle N -> rsp_valid = 1 with inst/fault/fault_cause at N+1; rsp_valid = 0 in cycles after no req.
REQ-017 Word index = pc >> 2; fault priority: pc[1:0] != 0 -> 01; else index >= DEPTH -> 10; else state != READY or index >= loaded_cnt -> 11.
REQ-018 Faulted response: inst = HALT_WORD, fault = 1; good response: inst = mem[index], fault = 0, fault_cause = 00.
REQ-019 Back-to-back req every cycle SHALL give one response per cycle, no bubbles.
REQ-020 Fetch and load in the same cycle: fetch sees pre-write contents and pre-increment loaded_cnt.
REQ-021 inst, fault, fault_cause SHALL hold last values when rsp_valid = 0.
REQ-022 Index range checks SHALL use full 30-bit pc[31:2] (no wrap-around of high address bits).

Reset
REQ-023 rst_n low SHALL immediately force: state EMPTY, ld_ready 0, rsp_valid 0, inst 0, fault 0, fault_cause 00, mem_ready 0, loaded_cnt 0, ovf 0.
REQ-024 Reset mid-load or mid-fetch SHALL abort; in-flight response never appears; memory array contents need not be reset but are unreachable until reloaded.
REQ-025 Deassertion SHALL be synchronised so first active edge after rst_n rises is a normal cycle.

Verification
REQ-026 Load 19-word factorial image (word0 32'h00600513 ... ld_last on word18) -> mem_ready 1, loaded_cnt 19; fetch pc 0 -> inst 32'h00600513, fault 0 next cycle.
REQ-027 After REQ-026, fetch pc 76 -> inst 32'h0000007F, fault 1, cause 11; fetch pc 256 (DEPTH 64) -> cause 10; fetch pc 6 -> cause 01.
REQ-028 Stream 65 words, ld_valid held, no ld_last, DEPTH 64 -> ld_ready 0 after 64th, ovf 1, loaded_cnt 64; then ld_last with ld_valid -> READY.
REQ-029 req every cycle pc 0,4,8,12 -> four consecutive rsp_valid cycles, inst = words 0..3 in order.
REQ-030 rst_n low during LOAD after 5 words -> all outputs reset value same cycle; fetch pc 0 after release -> cause 11.
REQ-031 In READY, ld_start then 2 words with ld_last -> loaded_cnt 2; fetch pc 8 -> cause 11, fetch pc 4 -> new word1.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction memory with a streaming loader and a fixed one-cycle fetch port.
// The loader fills words from index 0 upward. Fetches are checked for
// alignment, range and load status. A faulted fetch returns a halt word.
module imem_loader #(
  parameter int unsigned        DATA_W    = 32,
  parameter int unsigned        DEPTH     = 64,
  parameter logic [DATA_W-1:0]  HALT_WORD = DATA_W'(32'h0000007F),
  localparam int unsigned       CNT_W     = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  // Load stream
  input  logic              ld_start,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  // Fetch port
  input  logic              req,
  input  logic [31:0]       pc,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] inst,
  output logic              fault,
  output logic [1:0]        fault_cause,
  // Status
  output logic              mem_ready,
  output logic [CNT_W-1:0]  loaded_cnt,
  output logic              ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {StEmpty, StLoad, StReady} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   ptr_q, ptr_d;
  logic               ovf_q, ovf_d;
  logic               wr_en;
  logic               full;

  logic [DATA_W-1:0]  mem [DEPTH];

  logic [29:0]        idx;
  logic               in_range;
  logic               is_loaded;
  logic [1:0]         cause;
  logic [DATA_W-1:0]  rd_word;

  logic               rsp_valid_q;
  logic [DATA_W-1:0]  inst_q;
  logic               fault_q;
  logic [1:0]         cause_q;

  // Load FSM next-state, write enable and ready.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    wr_en    = 1'b0;
    full     = (ptr_q == CNT_W'(DEPTH));
    ld_ready = (state_q == StLoad) && !full;
    unique case (state_q)
      StEmpty, StReady: begin
        if (ld_start) begin
          state_d = StLoad;
          ptr_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      StLoad: begin
        if (ld_start) begin
          // Restart wins over any word presented in the same cycle.
          ptr_d = '0;
          ovf_d = 1'b0;
        end else if (ld_valid) begin
          if (!full) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + 1'b1;
          end else begin
            ovf_d = 1'b1;
          end
          if (ld_last) begin
            state_d = StReady;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Load FSM state, pointer and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents survive reset but are gated by the loaded count.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[ptr_q[AW-1:0]] <= ld_data;
    end
  end

  // Fetch classification; uses the full word index so high pc bits cannot alias.
  always_comb begin
    idx       = pc[31:2];
    in_range  = (idx < 30'(DEPTH));
    is_loaded = (idx < {{(30 - CNT_W){1'b0}}, ptr_q});
    rd_word   = mem[idx[AW-1:0]];
    cause     = 2'b00;
    if (pc[1:0] != 2'b00) begin
      cause = 2'b01;
    end else if (!in_range) begin
      cause = 2'b10;
    end else if ((state_q != StReady) || !is_loaded) begin
      cause = 2'b11;
    end
  end

  // Response register; payload holds its value when no request is made.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      inst_q      <= '0;
      fault_q     <= 1'b0;
      cause_q     <= 2'b00;
    end else begin
      rsp_valid_q <= req;
      if (req) begin
        inst_q  <= (cause == 2'b00) ? rd_word : HALT_WORD;
        fault_q <= (cause != 2'b00);
        cause_q <= cause;
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign inst        = inst_q;
  assign fault       = fault_q;
  assign fault_cause = cause_q;
  assign mem_ready   = (state_q == StReady);
  assign loaded_cnt  = ptr_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a transaction-level reference model.
module tb_imem_loader;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam logic [31:0] HALT   = 32'h0000007F;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ld_start = 1'b0;
  logic              ld_valid = 1'b0;
  logic [DATA_W-1:0] ld_data = '0;
  logic              ld_last = 1'b0;
  logic              ld_ready;
  logic              req = 1'b0;
  logic [31:0]       pc = '0;
  logic              rsp_valid;
  logic [DATA_W-1:0] inst;
  logic              fault;
  logic [1:0]        fault_cause;
  logic              mem_ready;
  logic [CNT_W-1:0]  loaded_cnt;
  logic              ovf;

  int checks = 0;
  int errors = 0;

  imem_loader #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .HALT_WORD(HALT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_start   (ld_start),
    .ld_valid   (ld_valid),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .req        (req),
    .pc         (pc),
    .rsp_valid  (rsp_valid),
    .inst       (inst),
    .fault      (fault),
    .fault_cause(fault_cause),
    .mem_ready  (mem_ready),
    .loaded_cnt (loaded_cnt),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  // Reference model: the loaded image is a queue, status is a small phase code.
  int          m_phase = 0;  // 0 empty, 1 loading, 2 ready
  logic [31:0] m_img[$];
  bit          m_ovf = 1'b0;
  bit          e_rsp = 1'b0;
  logic [31:0] e_inst = '0;
  bit          e_fault = 1'b0;
  logic [1:0]  e_cause = 2'b00;

  function automatic logic [1:0] classify(logic [31:0] a);
    int unsigned word;
    word = a >> 2;
    if ((a % 4) != 0) return 2'b01;
    if (word >= DEPTH) return 2'b10;
    if ((m_phase != 2) || (word >= m_img.size())) return 2'b11;
    return 2'b00;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [1:0] c;
    if (!rst_n) begin
      m_phase = 0;
      m_img.delete();
      m_ovf   = 1'b0;
      e_rsp   = 1'b0;
      e_inst  = '0;
      e_fault = 1'b0;
      e_cause = 2'b00;
    end else begin
      // Fetch is judged against the image as it stood before this edge.
      e_rsp = req;
      if (req) begin
        c       = classify(pc);
        e_cause = c;
        e_fault = (c != 2'b00);
        e_inst  = (c == 2'b00) ? m_img[pc >> 2] : HALT;
      end
      if (ld_start) begin
        m_phase = 1;
        m_img.delete();
        m_ovf = 1'b0;
      end else if ((m_phase == 1) && ld_valid) begin
        if (m_img.size() < DEPTH) m_img.push_back(ld_data);
        else m_ovf = 1'b1;
        if (ld_last) m_phase = 2;
      end
    end
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    chk("ld_ready", 64'(ld_ready), 64'((m_phase == 1) && (m_img.size() < DEPTH)));
    chk("mem_ready", 64'(mem_ready), 64'(m_phase == 2));
    chk("loaded_cnt", 64'(loaded_cnt), 64'(m_img.size()));
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
    chk("inst", 64'(inst), 64'(e_inst));
    chk("fault", 64'(fault), 64'(e_fault));
    chk("fault_cause", 64'(fault_cause), 64'(e_cause));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask

  task automatic load_word(logic [31:0] d, logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic fetch(logic [31:0] a);
    req = 1'b1;
    pc  = a;
    step();
    req = 1'b0;
  endtask

  logic [31:0] fact[19];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fact = '{32'h00600513, 32'h00100593, 32'h00050863, 32'h02a585b3, 32'hfff50513,
             32'hff5ff06f, 32'h00b02023, 32'h00100013, 32'h00200013, 32'h00300013,
             32'h00400013, 32'h00500013, 32'h00600013, 32'h00700013, 32'h00800013,
             32'h00900013, 32'h00a00013, 32'h00b00013, 32'h0000006f};

    step();
    step();
    chk("reset_ld_ready", 64'(ld_ready), 64'd0);
    chk("reset_cnt", 64'(loaded_cnt), 64'd0);
    chk("reset_rsp", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;

    // Fetch before anything is loaded.
    fetch(32'h0);
    chk("empty_cause", 64'(fault_cause), 64'd3);

    // Factorial image.
    start_load();
    for (int i = 0; i < 19; i++) begin
      if (i == 0) begin
        req = 1'b1;  // fetch concurrent with the first load word
        pc  = 32'h0;
      end
      load_word(fact[i], i == 18);
      req = 1'b0;
    end
    chk("fact_mem_ready", 64'(mem_ready), 64'd1);
    chk("fact_cnt", 64'(loaded_cnt), 64'd19);

    fetch(32'h0);
    chk("pc0_inst", 64'(inst), 64'h00600513);
    chk("pc0_fault", 64'(fault), 64'd0);
    fetch(32'd76);
    chk("pc76_inst", 64'(inst), 64'h0000007F);
    chk("pc76_cause", 64'(fault_cause), 64'd3);
    fetch(32'd256);
    chk("pc256_cause", 64'(fault_cause), 64'd2);
    fetch(32'd6);
    chk("pc6_cause", 64'(fault_cause), 64'd1);
    fetch(32'h8000_0000);
    chk("high_pc_cause", 64'(fault_cause), 64'd2);

    // Back-to-back fetches, then a hold cycle.
    for (int i = 0; i < 4; i++) begin
      req = 1'b1;
      pc  = 32'(i * 4);
      step();
      chk("b2b_valid", 64'(rsp_valid), 64'd1);
      chk("b2b_inst", 64'(inst), 64'(fact[i]));
    end
    req = 1'b0;
    step();
    chk("hold_valid", 64'(rsp_valid), 64'd0);
    chk("hold_inst", 64'(inst), 64'h02a585b3);

    // Reload with a short image.
    start_load();
    load_word(32'h11111111, 1'b0);
    load_word(32'h22222222, 1'b1);
    chk("reload_cnt", 64'(loaded_cnt), 64'd2);
    fetch(32'd8);
    chk("reload_pc8_cause", 64'(fault_cause), 64'd3);
    fetch(32'd4);
    chk("reload_pc4_inst", 64'(inst), 64'h22222222);

    // Restart mid-load drops the coincident word.
    start_load();
    load_word(32'h33333333, 1'b0);
    ld_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 32'h44444444;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b0;
    chk("restart_cnt", 64'(loaded_cnt), 64'd0);
    load_word(32'h55555555, 1'b1);
    fetch(32'h0);
    chk("restart_inst", 64'(inst), 64'h55555555);

    // Overflow: 65 words streamed into a 64-word memory.
    start_load();
    for (int i = 0; i < 65; i++) begin
      ld_valid = 1'b1;
      ld_data  = 32'hA000_0000 + 32'(i);
      step();
      if (i == 63) chk("full_ld_ready", 64'(ld_ready), 64'd0);
    end
    chk("ovf_set", 64'(ovf), 64'd1);
    chk("ovf_cnt", 64'(loaded_cnt), 64'd64);
    ld_last = 1'b1;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk("ovf_ready", 64'(mem_ready), 64'd1);
    fetch(32'd252);
    chk("last_word", 64'(inst), 64'hA000003F);

    // Reset in the middle of a load with a fetch in flight.
    start_load();
    for (int i = 0; i < 5; i++) load_word(32'hC000_0000 + 32'(i), 1'b0);
    req      = 1'b1;
    pc       = 32'h0;
    ld_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_rsp", 64'(rsp_valid), 64'd0);
    chk("rst_cnt", 64'(loaded_cnt), 64'd0);
    chk("rst_ld_ready", 64'(ld_ready), 64'd0);
    req      = 1'b0;
    ld_valid = 1'b0;
    step();
    step();
    chk("rst_hold_rsp", 64'(rsp_valid), 64'd0);
    rst_n = 1'b1;
    fetch(32'h0);
    chk("post_rst_cause", 64'(fault_cause), 64'd3);
    chk("post_rst_inst", 64'(inst), 64'h0000007F);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
